// File: rtl/cnn_pkg.sv
// cnn_pkg: definitions shared by the CNN streaming stages (add_layer, max_pool_2x2).
//   DATA_WIDTH : pixel width, IEEE-754 binary32
//   FP_ZERO    : +0.0 bit pattern
//   FRAME_D    : feature-map width/height produced by add_layer
//   fp_max()   : sign-magnitude total-order max of two binary32 patterns
package cnn_pkg;

    localparam int          DATA_WIDTH = 32;
    localparam logic [31:0] FP_ZERO    = 32'h0000_0000;
    localparam int          FRAME_D    = 299;

    // Ordering on raw bit patterns: positive beats negative (so -0 < +0),
    // larger magnitude wins among positives, smaller among negatives.
    // NaNs fall out of this ordering like any other pattern. Ties keep a.
    function automatic logic [31:0] fp_max(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        if (a[31] != b[31])
            r = a[31] ? b : a;
        else if (!a[31])
            r = (b[30:0] > a[30:0]) ? b : a;
        else
            r = (b[30:0] < a[30:0]) ? b : a;
        return r;
    endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// pool_line_buffer: DEPTH x W register array holding the per-column-pair
// maxima of the even row of each window row-pair.
//   clk     : clock
//   we_i    : write enable
//   waddr_i : write index (col >> 1)
//   wdata_i : horizontal max of the even-row pixel pair
//   raddr_i : read index (col >> 1)
//   rdata_o : combinational read data
// Contents are never reset: every entry is written on an even row before
// the following odd row reads it.
module pool_line_buffer #(
    parameter int DEPTH = 149,
    parameter int W     = 32,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i)
            mem_q[waddr_i] <= wdata_i;
    end

    // Out-of-range indices only occur outside the pooling window, where the
    // read data is ignored.
    always_comb begin
        rdata_o = '0;
        if (int'(raddr_i) < DEPTH)
            rdata_o = mem_q[raddr_i];
    end

endmodule

// File: rtl/max_pool_2x2.sv
// max_pool_2x2: streaming 2x2 / stride-2 max pooling over a D x D binary32
// raster stream, producing a floor(D/2) x floor(D/2) raster stream.
//   clk       : clock, posedge
//   reset     : synchronous, active-high
//   valid_in  : pxl_in valid this cycle (gaps allowed)
//   pxl_in    : input pixel, row-major
//   valid_out : one-cycle pulse, pxl_out carries a pooled pixel
//   pxl_out   : pooled pixel, held while valid_out is low
// Optional build macro POOL_RELU_EN: negative pooled results are forced to +0.
module max_pool_2x2
    import cnn_pkg::*;
#(
    parameter int D          = FRAME_D,
    parameter int data_width = DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [data_width-1:0] pxl_in,
    output logic                  valid_out,
    output logic [data_width-1:0] pxl_out
);

    localparam int HALF = D / 2;
    localparam int WIN  = 2 * HALF;           // rows/cols that belong to a window
    localparam int COLW = $clog2(D);
    localparam int IDXW = (HALF > 1) ? $clog2(HALF) : 1;

    logic [COLW-1:0]       col_q, col_d;
    logic [COLW-1:0]       row_q, row_d;
    logic [data_width-1:0] h_q, h_d;          // even-column pixel of current pair
    logic [data_width-1:0] pxl_q, pxl_d;
    logic                  vld_q, vld_d;

    logic                  in_win;
    logic [IDXW-1:0]       lb_idx;
    logic                  lb_we;
    logic [data_width-1:0] lb_rdata;
    logic [data_width-1:0] hmax;
    logic [data_width-1:0] pooled;

    // Last column/row of an odd-sized map never joins a window.
    assign in_win = (int'(col_q) < WIN) && (int'(row_q) < WIN);
    assign lb_idx = IDXW'(col_q >> 1);
    assign hmax   = fp_max(h_q, pxl_in);
    assign pooled = fp_max(lb_rdata, hmax);
    assign lb_we  = valid_in && in_win && col_q[0] && !row_q[0];

    pool_line_buffer #(
        .DEPTH (HALF),
        .W     (data_width),
        .AW    (IDXW)
    ) u_lbuf (
        .clk     (clk),
        .we_i    (lb_we),
        .waddr_i (lb_idx),
        .wdata_i (hmax),
        .raddr_i (lb_idx),
        .rdata_o (lb_rdata)
    );

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        h_d   = h_q;
        pxl_d = pxl_q;
        vld_d = 1'b0;
        if (valid_in) begin
            if (col_q == COLW'(D - 1)) begin
                col_d = '0;
                row_d = (row_q == COLW'(D - 1)) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
            if (in_win && !col_q[0])
                h_d = pxl_in;
            // Odd column of an odd row completes the window.
            if (in_win && col_q[0] && row_q[0]) begin
                vld_d = 1'b1;
`ifdef POOL_RELU_EN
                pxl_d = pooled[data_width-1] ? FP_ZERO : pooled;
`else
                pxl_d = pooled;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_q <= '0;
            row_q <= '0;
            h_q   <= '0;
            pxl_q <= '0;
            vld_q <= 1'b0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            h_q   <= h_d;
            pxl_q <= pxl_d;
            vld_q <= vld_d;
        end
    end

    assign valid_out = vld_q;
    assign pxl_out   = pxl_q;

endmodule

// File: tb/tb_max_pool_2x2.sv
module tb_max_pool_2x2;

`ifdef POOL_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        v4, v5;
    logic [31:0] p4, p5;
    logic        o4v, o5v;
    logic [31:0] o4p, o5p;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [31:0] q4[$];
    int          c4[$];
    logic [31:0] q5[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    max_pool_2x2 #(.D(4), .data_width(32)) u4 (
        .clk(clk), .reset(reset), .valid_in(v4), .pxl_in(p4),
        .valid_out(o4v), .pxl_out(o4p));

    max_pool_2x2 #(.D(5), .data_width(32)) u5 (
        .clk(clk), .reset(reset), .valid_in(v5), .pxl_in(p5),
        .valid_out(o5v), .pxl_out(o5p));

    // Capture pulses away from the active edge; c4 records the edge number
    // at which the pulse was registered.
    always @(negedge clk) begin
        if (o4v) begin
            q4.push_back(o4p);
            c4.push_back(cyc);
        end
        if (o5v) q5.push_back(o5p);
    end

    // Small positive integer n (or its negation) as binary32 bits.
    function automatic logic [31:0] fl(input int n);
        int m;
        int e;
        logic [31:0] r;
        m = (n < 0) ? -n : n;
        e = 0;
        while ((m >> (e + 1)) != 0) e++;
        r[31]    = (n < 0);
        r[30:23] = 8'(127 + e);
        r[22:0]  = 23'(m << (23 - e));
        return r;
    endfunction

    // Drive one pixel into DUT4/DUT5; edge_n is the posedge that consumes it.
    task automatic px(input bit sel5, input logic [31:0] p, output int edge_n);
        @(negedge clk);
        v4 = 1'b0; v5 = 1'b0;
        if (sel5) begin v5 = 1'b1; p5 = p; end
        else      begin v4 = 1'b1; p4 = p; end
        edge_n = cyc + 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            v4 = 1'b0; v5 = 1'b0;
            p4 = 32'hDEADBEEF; p5 = 32'hDEADBEEF;
        end
    endtask

    task automatic flush();
        idle(3);
        q4.delete(); c4.delete(); q5.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1; v4 = 1'b0; v5 = 1'b0; p4 = '0; p5 = '0;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (o4v !== 1'b0) begin fails++; $display("FAIL reset_vld4 got %b want 0", o4v); end
        tests++; if (o4p !== 32'h0) begin fails++; $display("FAIL reset_pxl4 got %h want 0", o4p); end
        tests++; if (o5v !== 1'b0) begin fails++; $display("FAIL reset_vld5 got %b want 0", o5v); end
        tests++; if (o5p !== 32'h0) begin fails++; $display("FAIL reset_pxl5 got %h want 0", o5p); end
        @(negedge clk);
        reset = 1'b0;
        flush();
    endtask

    // Scenario-1 frame on DUT4, optionally with one idle cycle after each pixel.
    task automatic frame4(input bit gaps, input bit neg, output int br[4]);
        int e;
        for (int i = 1; i <= 16; i++) begin
            px(1'b0, fl(neg ? -i : i), e);
            if (i == 6)  br[0] = e;
            if (i == 8)  br[1] = e;
            if (i == 14) br[2] = e;
            if (i == 16) br[3] = e;
            if (gaps) idle(1);
        end
    endtask

    task automatic check_frame4(input string tag, input int br[4]);
        logic [31:0] exp_v[4];
        exp_v = '{32'h40C00000, 32'h41000000, 32'h41600000, 32'h41800000};
        tests++;
        if (q4.size() != 4) begin
            fails++; $display("FAIL %s_count got %0d want 4", tag, q4.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                tests++;
                if (q4[k] !== exp_v[k]) begin fails++; $display("FAIL %s_val%0d got %h want %h", tag, k, q4[k], exp_v[k]); end
                tests++;
                if (c4[k] != br[k]) begin fails++; $display("FAIL %s_lat%0d got edge %0d want %0d", tag, k, c4[k], br[k]); end
            end
        end
    endtask

    task automatic test_basic();
        int br[4];
        frame4(1'b0, 1'b0, br);
        idle(3);
        check_frame4("basic", br);
        flush();
    endtask

    task automatic test_negative();
        logic [31:0] img[16];
        logic [31:0] want;
        int e;
        for (int i = 0; i < 16; i++) img[i] = 32'h3F800000;
        img[0] = 32'hBF800000; img[1] = 32'hC0400000;
        img[4] = 32'hC0000000; img[5] = 32'hBF000000;
        for (int i = 0; i < 16; i++) px(1'b0, img[i], e);
        idle(3);
        want = RELU ? 32'h00000000 : 32'hBF000000;
        tests++;
        if (q4.size() != 4) begin
            fails++; $display("FAIL neg_count got %0d want 4", q4.size());
        end else begin
            tests++;
            if (q4[0] !== want) begin fails++; $display("FAIL neg_first got %h want %h", q4[0], want); end
            tests++;
            if (q4[3] !== 32'h3F800000) begin fails++; $display("FAIL neg_last got %h want 3F800000", q4[3]); end
        end
        flush();
    endtask

    task automatic test_odd();
        logic [31:0] exp_v[4];
        int e;
        exp_v = '{32'h40E00000, 32'h41100000, 32'h41880000, 32'h41980000};
        for (int i = 1; i <= 25; i++) px(1'b1, fl(i), e);
        idle(3);
        tests++;
        if (q5.size() != 4) begin
            fails++; $display("FAIL odd_count got %0d want 4", q5.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                tests++;
                if (q5[k] !== exp_v[k]) begin fails++; $display("FAIL odd_val%0d got %h want %h", k, q5[k], exp_v[k]); end
            end
        end
        flush();
    endtask

    task automatic test_gaps();
        int br[4];
        frame4(1'b1, 1'b0, br);
        idle(3);
        check_frame4("gaps", br);
        flush();
    endtask

    task automatic test_reset_mid();
        int br[4];
        int e;
        for (int i = 1; i <= 6; i++) px(1'b0, fl(100 + i), e);
        @(negedge clk);
        v4 = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        q4.delete(); c4.delete();
        tests++; if (o4v !== 1'b0) begin fails++; $display("FAIL midrst_vld got %b want 0", o4v); end
        tests++; if (o4p !== 32'h0) begin fails++; $display("FAIL midrst_pxl got %h want 0", o4p); end
        @(negedge clk);
        reset = 1'b0;
        frame4(1'b0, 1'b0, br);
        idle(3);
        check_frame4("midrst", br);
        flush();
    endtask

    task automatic test_back_to_back();
        int br[4];
        logic [31:0] exp_v[4];
        frame4(1'b0, 1'b0, br);
        frame4(1'b0, 1'b1, br);
        idle(3);
        if (RELU) exp_v = '{32'h0, 32'h0, 32'h0, 32'h0};
        else      exp_v = '{32'hBF800000, 32'hC0400000, 32'hC1100000, 32'hC1300000};
        tests++;
        if (q4.size() != 8) begin
            fails++; $display("FAIL b2b_count got %0d want 8", q4.size());
        end else begin
            tests++;
            if (q4[3] !== 32'h41800000) begin fails++; $display("FAIL b2b_f1last got %h want 41800000", q4[3]); end
            for (int k = 0; k < 4; k++) begin
                tests++;
                if (q4[4+k] !== exp_v[k]) begin fails++; $display("FAIL b2b_val%0d got %h want %h", k, q4[4+k], exp_v[k]); end
                tests++;
                if (c4[4+k] != br[k]) begin fails++; $display("FAIL b2b_lat%0d got edge %0d want %0d", k, c4[4+k], br[k]); end
            end
        end
        flush();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_odd();
        test_gaps();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/max_pool_2x2.md
Name: max_pool_2x2

Overview:
Streaming 2x2, stride-2 max-pooling stage placed directly downstream of add_layer; consumes its pxl_out/valid_out raster stream.
- Input: one D x D feature map of IEEE-754 single-precision pixels, row-major, one pixel per valid cycle.
- Output: floor(D/2) x floor(D/2) map, row-major, in the same format.
- Uses one line buffer of floor(D/2) entries; no frame buffer.

Parameters:
D, 299, input map width and height in pixels (D >= 2)
data_width, 32, pixel width; fixed at 32 (IEEE-754 binary32)

Ports:
clk  input  1  single clock; all logic on posedge
reset  input  1  synchronous, active-high reset
valid_in  input  1  pxl_in valid this cycle; may be deasserted at any cycle (gaps allowed)
pxl_in  input  data_width  input pixel, raster order
valid_out  output  1  one-cycle pulse; pxl_out holds a pooled pixel
pxl_out  output  data_width  pooled pixel (max of 2x2 window)

Behaviour:
- Reset (synchronous, active-high): valid_out=0, pxl_out=0, col=0, row=0. Line buffer is not cleared; it is always written before it is read.
- Counters: col 0..D-1 and row 0..D-1 advance only on valid_in.
  - col wraps to 0 at D-1, and row increments on that wrap.
  - row wraps to 0 at D-1 with col=D-1 (end of frame).
  - Next frame follows back-to-back with no idle cycle required.
- Odd D: pixels with col=D-1 or row=D-1 are consumed by the counters but never enter a window, and produce no output. D=299 gives 149x149 outputs.
- Even row (row[0]=0), col<2*floor(D/2):
  - even col: hold pixel in h_reg.
  - odd col: lbuf[col>>1] <= fpmax(h_reg, pxl_in).
- Odd row, col<2*floor(D/2):
  - even col: hold pixel in h_reg.
  - odd col: pxl_out <= fpmax(lbuf[col>>1], fpmax(h_reg, pxl_in)) and valid_out <= 1.
- valid_out is 0 on every other cycle.
- Latency: valid_out asserts exactly 1 clk after the valid_in cycle carrying the window's bottom-right pixel.
- pxl_out holds its last value while valid_out=0.
- Throughput: 1 pixel/clk sustained, no stall or backpressure. The downstream stage must accept every valid_out pulse.
- fpmax(a,b) uses a sign-magnitude total order:
  - Both non-negative: larger magnitude wins.
  - Both negative: smaller magnitude wins.
  - Mixed signs: positive wins.
  - -0 < +0.
  - Ties return a.
  - NaN is not special-cased; it is ordered by its bit pattern.
- Reset mid-frame: partial window discarded; the next valid_in is treated as pixel (0,0).

Optional Feature:
POOL_RELU_EN
- Defined: fused ReLU. If the pooled result has sign bit 1, pxl_out <= 32'h00000000. Timing and valid_out are unchanged.
- Undefined: pxl_out is the raw max, and negative results pass through.

Decomposition:
- Shared package cnn_pkg holds:
  - DATA_WIDTH=32.
  - FP_ZERO=32'h00000000.
  - fp_max function (sign-magnitude compare).
  - Frame-dimension constants shared with add_layer.
- One natural sub-module, pool_line_buffer: a floor(D/2)-entry, data_width-wide, single-write/single-read register array indexed by col>>1. Reads and writes never target the same cycle/row parity.

Test Plan:
- D=4, pixels 1.0..16.0 raster (3F800000..41800000), valid_in continuous -> 4 pulses in order: 6.0 (40C00000), 8.0 (41000000), 14.0 (41600000), 16.0 (41800000). Each pulse arrives 1 clk after pixels 6, 8, 14, 16 respectively.
- D=4, top-left window -1.0, -3.0, -2.0, -0.5 (BF800000, C0400000, C0000000, BF000000), remaining pixels 1.0 -> first output BF000000. With POOL_RELU_EN, first output is 00000000.
- D=5, pixels 1.0..25.0 -> exactly 4 outputs: 7.0, 9.0, 17.0, 19.0 (40E00000, 41100000, 41880000, 41980000). No pulse for col 4 or row 4.
- D=4 frame from scenario 1 with valid_in high on alternate cycles only, pxl_in=DEADBEEF when low -> identical 4 outputs, each 1 clk after its bottom-right pixel.
- D=4: reset held for 1 clk after 6 pixels, then full scenario-1 frame -> exactly 4 pulses 6.0, 8.0, 14.0, 16.0. No pulse during or after reset caused by the partial data.
- D=4: two frames back-to-back, second frame = first frame negated -> 8 pulses. The last 4 are -1.0, -3.0, -9.0, -11.0 (BF800000, C0400000, C1100000, C1300000).
